// File: rtl/led_sequencer_pkg.sv
// led_sequencer_pkg: register offsets, CTRL/STATUS bit positions and FSM states shared by the LED sequencer.
package led_sequencer_pkg;
    localparam logic [3:0] OFF_CTRL         = 4'h0;
    localparam logic [3:0] OFF_PERIOD       = 4'h1;
    localparam logic [3:0] OFF_STATUS       = 4'h2;
    localparam logic [3:0] OFF_DIRECT       = 4'h3;
    localparam logic [3:0] OFF_PATTERN_BASE = 4'h8;
    localparam int CTRL_EN    = 0;
    localparam int CTRL_LOOP  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_LAST  = 8;
    localparam int ST_BUSY = 0;
    localparam int ST_IDX  = 4;
    localparam int ST_DONE = 8;
    localparam int ST_DROP = 9;
    localparam int ST_ERR  = 10;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/led_sequencer_regs.sv
// led_sequencer_regs: slave decode, CTRL/PERIOD/STATUS registers, pattern table and W1C flags.
// Ports: clk, reset (sync, active-high); slave read/write/address/write_data/read_data/response;
// enable/loop/last_idx/period/start to the FSM; direct_wr/direct_byte for CPU LED writes;
// pat_idx/pat_byte table read port; busy/cur_idx/set_done/set_drop/set_err status inputs.
// Macro LEDSEQ_TIMEOUT_EN adds the err flag; otherwise err reads 0.
module led_sequencer_regs
    import led_sequencer_pkg::*;
#(
    parameter int PATTERN_DEPTH = 8,
    parameter int PERIOD_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    read,
    input  logic                    write,
    input  logic [31:0]             address,
    input  logic [31:0]             write_data,
    output logic [31:0]             read_data,
    output logic                    response,
    output logic                    enable,
    output logic                    loop,
    output logic                    start,
    output logic [2:0]              last_idx,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    direct_wr,
    output logic [7:0]              direct_byte,
    input  logic [2:0]              pat_idx,
    output logic [7:0]              pat_byte,
    input  logic                    busy,
    input  logic [2:0]              cur_idx,
    input  logic                    set_done,
    input  logic                    set_drop,
    input  logic                    set_err
);
    localparam logic [3:0] DEPTH4   = 4'(PATTERN_DEPTH);
    localparam logic [2:0] LAST_MAX = 3'(PATTERN_DEPTH - 1);
    logic [3:0]  off;
    logic [7:0]  pattern [8];
    logic        done, drop, err, pat_hit, w_status;
    logic [2:0]  last_in;
    logic [31:0] ctrl_rd, status_rd, rd_word;
    logic        unused_ok;
    assign off         = address[5:2];
    assign pat_hit     = off[3] && ({1'b0, off[2:0]} < DEPTH4);
    assign w_status    = write && off == OFF_STATUS;
    assign last_in     = write_data[CTRL_LAST +: 3] > LAST_MAX ? LAST_MAX : write_data[CTRL_LAST +: 3];
    // start only fires together with a newly written enable=1
    assign start       = write && off == OFF_CTRL && write_data[CTRL_START] && write_data[CTRL_EN];
    assign direct_wr   = write && off == OFF_DIRECT;
    assign direct_byte = write_data[7:0];
    assign pat_byte    = pattern[pat_idx];
    assign response    = read | write;
    always_ff @(posedge clk) begin
        if (reset) begin
            enable   <= 1'b0;
            loop     <= 1'b0;
            last_idx <= '0;
            period   <= '0;
            done     <= 1'b0;
            drop     <= 1'b0;
            for (int i = 0; i < 8; i++) pattern[i] <= '0;
        end else begin
            if (write && off == OFF_CTRL) begin
                enable   <= write_data[CTRL_EN];
                loop     <= write_data[CTRL_LOOP];
                last_idx <= last_in;
            end
            if (write && off == OFF_PERIOD) period <= write_data[PERIOD_WIDTH-1:0];
            if (write && pat_hit) pattern[off[2:0]] <= write_data[7:0];
            // hardware set takes priority over a same-cycle W1C clear
            done <= set_done | (done & ~(w_status & write_data[ST_DONE]));
            drop <= set_drop | (drop & ~(w_status & write_data[ST_DROP]));
        end
    end
`ifdef LEDSEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) err <= 1'b0;
        else err <= set_err | (err & ~(w_status & write_data[ST_ERR]));
    end
    assign unused_ok = ^{address[31:6], address[1:0]};
`else
    assign err       = 1'b0;
    assign unused_ok = ^{address[31:6], address[1:0], set_err};
`endif
    always_comb begin
        ctrl_rd                  = '0;
        ctrl_rd[CTRL_EN]         = enable;
        ctrl_rd[CTRL_LOOP]       = loop;
        ctrl_rd[CTRL_LAST +: 3]  = last_idx;
        status_rd                = '0;
        status_rd[ST_BUSY]       = busy;
        status_rd[ST_IDX +: 3]   = cur_idx;
        status_rd[ST_DONE]       = done;
        status_rd[ST_DROP]       = drop;
        status_rd[ST_ERR]        = err;
    end
    assign rd_word = off == OFF_CTRL   ? ctrl_rd :
                     off == OFF_PERIOD ? 32'(period) :
                     off == OFF_STATUS ? status_rd :
                     pat_hit           ? {24'd0, pattern[off[2:0]]} : '0;
    assign read_data = read ? rd_word : '0;
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: steps an 8-entry pattern table out to the LED peripheral over a bus master port.
// Ports: clk, reset (sync, active-high); slave read/write/address/write_data/read_data/response;
// master m_read (always 0)/m_write/m_address (= LED_ADDR)/m_write_data/m_read_data (unused)/m_response.
// Macro LEDSEQ_TIMEOUT_EN aborts an ISSUE with err after TIMEOUT_CYCLES without m_response.
module led_sequencer
    import led_sequencer_pkg::*;
#(
    parameter int          PATTERN_DEPTH  = 8,
    parameter logic [31:0] LED_ADDR       = 32'h0000_0000,
    parameter int          PERIOD_WIDTH   = 32,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        response,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_address,
    output logic [31:0] m_write_data,
    input  logic [31:0] m_read_data,
    input  logic        m_response
);
    state_t                  state, state_d;
    logic [2:0]              idx, idx_d, last_idx, pat_idx;
    logic [7:0]              data_q, direct_byte, pat_byte;
    logic [PERIOD_WIDTH-1:0] cnt, cnt_d, period;
    logic                    one_shot, one_shot_d, restart_q, restart_d, go_start;
    logic                    enable, loop, start, direct_wr, busy;
    logic                    load, load_direct, set_done, set_err;
    logic                    unused_ok;
    assign busy         = state != IDLE;
    assign m_read       = 1'b0;
    assign m_write      = state == ISSUE;
    assign m_address    = LED_ADDR;
    assign m_write_data = {24'd0, data_q};
    assign pat_idx      = idx_d;
    assign unused_ok    = ^m_read_data;
    // a start seen during ISSUE is remembered and honoured once that write completes
    assign go_start     = start | (restart_q & enable);
    led_sequencer_regs #(.PATTERN_DEPTH(PATTERN_DEPTH), .PERIOD_WIDTH(PERIOD_WIDTH)) u_regs (
        .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
        .write_data(write_data), .read_data(read_data), .response(response),
        .enable(enable), .loop(loop), .start(start), .last_idx(last_idx), .period(period),
        .direct_wr(direct_wr), .direct_byte(direct_byte), .pat_idx(pat_idx), .pat_byte(pat_byte),
        .busy(busy), .cur_idx(idx), .set_done(set_done), .set_drop(direct_wr & busy),
        .set_err(set_err)
    );
`ifdef LEDSEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tcnt;
    logic        timeout;
    assign timeout = tcnt == TO_LAST;
    always_ff @(posedge clk) begin
        if (reset) tcnt <= '0;
        else tcnt <= (state == ISSUE && !load) ? tcnt + 16'd1 : '0;
    end
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            one_shot  <= 1'b0;
            restart_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            cnt       <= cnt_d;
            one_shot  <= one_shot_d;
            restart_q <= restart_d;
            if (load) data_q <= load_direct ? direct_byte : pat_byte;
        end
    end
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        cnt_d       = cnt;
        one_shot_d  = one_shot;
        restart_d   = restart_q;
        load        = 1'b0;
        load_direct = 1'b0;
        set_done    = 1'b0;
        set_err     = 1'b0;
        case (state)
            IDLE: begin
                restart_d = 1'b0;
                if (start) begin
                    idx_d      = '0;
                    one_shot_d = 1'b0;
                    load       = 1'b1;
                    state_d    = ISSUE;
                end else if (direct_wr) begin
                    one_shot_d  = 1'b1;
                    load        = 1'b1;
                    load_direct = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (start) restart_d = 1'b1;
                if (m_response) begin
                    if (go_start) begin
                        idx_d      = '0;
                        one_shot_d = 1'b0;
                        load       = 1'b1;
                        restart_d  = 1'b0;
                    end else if (one_shot || !enable) begin
                        restart_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d   = period;
                        state_d = HOLD;
                    end
                end
`ifdef LEDSEQ_TIMEOUT_EN
                else if (timeout) begin
                    set_err   = 1'b1;
                    restart_d = 1'b0;
                    state_d   = IDLE;
                end
`endif
            end
            HOLD: begin
                cnt_d = cnt - 1'b1;
                if (start) begin
                    idx_d   = '0;
                    load    = 1'b1;
                    state_d = ISSUE;
                end else if (!enable) begin
                    state_d = IDLE;
                end else if (cnt <= PERIOD_WIDTH'(1)) begin
                    if (idx < last_idx || loop) begin
                        idx_d   = idx < last_idx ? idx + 3'd1 : 3'd0;
                        load    = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        set_done = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: scoreboard bench for led_sequencer (direct, one-shot, loop, delayed, timeout, reset).
module tb_led_sequencer;
    logic        clk = 1'b0, reset = 1'b1, read = 1'b0, write = 1'b0;
    logic [31:0] address = '0, write_data = '0, m_read_data = '0;
    logic [31:0] read_data, m_address, m_write_data, hold_data, rd;
    logic        response, m_read, m_write, m_response;
    int          resp_mode = 0, wcnt = 0, cyc = 0, hold_n = 0, last_hold = 0;
    int          n_checks = 0, n_pass = 0, b = 0, n = 0;
    logic [31:0] sb [$];
    int          hs_times [$];

    always #5 clk = ~clk;

    assign m_response = resp_mode == 0 ? m_write :
                        resp_mode == 1 ? (m_write && wcnt >= 3) : 1'b0;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        wcnt <= (m_write && !m_response) ? wcnt + 1 : 0;
    end

    led_sequencer dut (
        .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
        .write_data(write_data), .read_data(read_data), .response(response),
        .m_read(m_read), .m_write(m_write), .m_address(m_address),
        .m_write_data(m_write_data), .m_read_data(m_read_data), .m_response(m_response)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        write = 1'b1; address = a; write_data = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        read = 1'b1; address = a;
        #1 d = read_data;
        read = 1'b0;
    endtask

    task automatic drain(input int limit);
        int k = 0;
        while (sb.size() != 0 && k < limit) begin
            @(posedge clk);
            k++;
        end
        check("drain", sb.size(), 0);
    endtask

    // master-side monitor: data must hold while waiting, each handshake pops the scoreboard
    always @(negedge clk) begin
        if (m_write) begin
            if (hold_n == 0) hold_data = m_write_data;
            else check("hold_stable", m_write_data, hold_data);
            hold_n++;
            if (m_response) begin
                last_hold = hold_n;
                hold_n = 0;
                hs_times.push_back(cyc);
                if (sb.size() == 0) check("unexpected_write", sb.size(), 1);
                else check("m_write_data", m_write_data, sb.pop_front());
            end
        end else begin
            if (hold_n != 0) last_hold = hold_n;
            hold_n = 0;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        check("rst_m_write", m_write, 0);
        check("rst_m_wdata", m_write_data, 0);
        check("m_read", m_read, 0);
        bus_rd(32'h00, rd); check("rst_ctrl", rd, 0);
        bus_rd(32'h04, rd); check("rst_period", rd, 0);
        bus_rd(32'h08, rd); check("rst_status", rd, 0);
        @(negedge clk); read = 1'b1; #1 check("response", response, 1); read = 1'b0;
        check("read_idle_zero", read_data, 0);

        // direct write while idle
        sb.push_back(32'h0000_00A5);
        bus_wr(32'h0C, 32'hFFFF_FFA5);
        drain(20);
        check("direct_hold", last_hold, 1);
        repeat (3) @(posedge clk);
        bus_rd(32'h08, rd); check("direct_status", rd, 0);

        // one-shot three-step run
        bus_wr(32'h20, 32'h01); bus_wr(32'h24, 32'h02); bus_wr(32'h28, 32'h04);
        bus_rd(32'h24, rd); check("pattern1_rd", rd, 32'h02);
        bus_wr(32'h04, 4);
        b = hs_times.size();
        sb.push_back(32'h01); sb.push_back(32'h02); sb.push_back(32'h04);
        bus_wr(32'h00, 32'h205);
        drain(100);
        check("oneshot_count", hs_times.size() - b, 3);
        check("gap0", hs_times[b+1] - hs_times[b], 5);
        check("gap1", hs_times[b+2] - hs_times[b+1], 5);
        repeat (8) @(posedge clk);
        bus_rd(32'h08, rd); check("oneshot_status", rd, 32'h120);
        bus_rd(32'h00, rd); check("ctrl_rd", rd, 32'h201);
        bus_wr(32'h08, 32'h100);
        bus_rd(32'h08, rd); check("done_w1c", rd, 32'h020);

        // loop run, then clear enable during HOLD
        sb.push_back(32'h01); sb.push_back(32'h02); sb.push_back(32'h04);
        sb.push_back(32'h01); sb.push_back(32'h02);
        bus_wr(32'h00, 32'h207);
        drain(100);
        bus_wr(32'h00, 32'h002);
        @(negedge clk);
        bus_rd(32'h08, rd); check("loop_stop_status", rd, 32'h010);
        repeat (10) @(posedge clk);
        check("loop_no_more", sb.size(), 0);

        // delayed response with a dropped DIRECT write
        resp_mode = 1;
        sb.push_back(32'h01);
        bus_wr(32'h00, 32'h005);
        bus_wr(32'h0C, 32'h77);
        drain(50);
        check("delayed_hold", last_hold, 4);
        repeat (8) @(posedge clk);
        bus_rd(32'h08, rd); check("drop_status", rd, 32'h300);
        bus_wr(32'h08, 32'h200);
        bus_rd(32'h08, rd); check("drop_w1c", rd, 32'h100);
        bus_wr(32'h08, 32'h300);

        // no response: timeout or indefinite wait, then reset mid-ISSUE
        resp_mode = 2;
        bus_wr(32'h00, 32'h005);
`ifdef LEDSEQ_TIMEOUT_EN
        n = 0;
        while (!m_write && n < 10) begin @(negedge clk); n++; end
        while (m_write && n < 60) begin @(negedge clk); n++; end
        repeat (2) @(posedge clk);
        check("timeout_hold", last_hold, 16);
        bus_rd(32'h08, rd); check("timeout_status", rd, 32'h400);
        bus_wr(32'h00, 32'h005);
        @(posedge clk);
`else
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("no_timeout_mwrite", m_write, 1);
        bus_rd(32'h08, rd); check("no_timeout_status", rd, 32'h001);
`endif
        @(negedge clk);
        check("pre_reset_issue", m_write, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 check("reset_mwrite", m_write, 0);
        @(negedge clk) reset = 1'b0;
        resp_mode = 0;
        check("reset_mwdata", m_write_data, 0);
        bus_rd(32'h00, rd); check("rr_ctrl", rd, 0);
        bus_rd(32'h04, rd); check("rr_period", rd, 0);
        bus_rd(32'h08, rd); check("rr_status", rd, 0);
        bus_rd(32'h20, rd); check("rr_pattern0", rd, 0);

        // unmapped offset ignores writes and reads 0
        bus_wr(32'h10, 32'hFFFF_FFFF);
        bus_rd(32'h10, rd); check("unmapped", rd, 0);

        // PERIOD=0 gives one-cycle steps
        bus_wr(32'h20, 32'h11); bus_wr(32'h24, 32'h22);
        b = hs_times.size();
        sb.push_back(32'h11); sb.push_back(32'h22);
        bus_wr(32'h00, 32'h105);
        drain(50);
        check("p0_count", hs_times.size() - b, 2);
        check("p0_gap", hs_times[b+1] - hs_times[b], 2);
        repeat (5) @(posedge clk);
        bus_rd(32'h08, rd); check("p0_status", rd, 32'h110);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Memory-mapped controller that autonomously drives the board LED peripheral through a bus master port.
- CPU programs an 8-entry pattern table, a step period and control bits via a slave port.
- Block steps through the table, issuing one write per step to the LED peripheral; CPU direct writes are forwarded when idle.
- Sits between the CPU peripheral bus and the LED peripheral; sole master of the LED peripheral.

Parameters:
- PATTERN_DEPTH, 8, pattern table entries; power of two, max 8.
- LED_ADDR, 32'h0000_0000, address driven on m_address for every master access.
- PERIOD_WIDTH, 32, width of period register and step counter.
- TIMEOUT_CYCLES, 16, response wait limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- read  in  1  slave read strobe
- write  in  1  slave write strobe
- address  in  32  slave byte address; only [5:2] decoded
- write_data  in  32  slave write data
- read_data  out  32  slave read data, combinational; 0 when read=0
- response  out  1  = read | write, combinational
- m_read  out  1  master read strobe, always 0
- m_write  out  1  master write strobe
- m_address  out  32  = LED_ADDR
- m_write_data  out  32  {24'b0, pattern byte}
- m_read_data  in  32  unused
- m_response  in  1  master handshake acknowledge

Behaviour:
- Register map, word offset = address[5:2]:
  - 0x00 CTRL, RW: [0] enable, [1] loop, [2] start (write-1 pulse, reads 0), [10:8] last_idx.
  - 0x04 PERIOD, RW: step period in cycles; 0 behaves as 1.
  - 0x08 STATUS, RO except W1C bits: [0] busy, [6:4] cur_idx, [8] done (W1C), [9] drop (W1C), [10] err (W1C).
  - 0x0C DIRECT, WO: byte forwarded to the LEDs.
  - 0x20-0x3C PATTERN[0..7], RW: [7:0] stored, upper bits read 0.
  - Unmapped offsets read 0; writes to them are ignored.
- Reset: all registers, STATUS, FSM and counters clear to 0; m_write = 0; m_write_data = 0.
- FSM states: IDLE, ISSUE, HOLD.
- IDLE:
  - start=1 with enable=1: cur_idx <= 0, go to ISSUE with PATTERN[0].
  - Else a DIRECT write: go to ISSUE with the DIRECT byte, flagged as a one-shot.
- ISSUE:
  - m_write = 1 and m_write_data stable until m_response is sampled 1.
  - Then a one-shot returns to IDLE; a sequence step loads the counter with PERIOD and goes to HOLD.
  - A same-cycle response gives a 1-cycle write.
- HOLD:
  - Counter decrements each cycle; at 1 (or PERIOD=0), advance.
  - If cur_idx < last_idx: cur_idx+1, go to ISSUE.
  - Else if loop: cur_idx <= 0, go to ISSUE.
  - Else: set done, go to IDLE.
- busy = (state != IDLE).
- last_idx is clamped to PATTERN_DEPTH-1.
- enable cleared while busy:
  - In ISSUE, the transaction completes, then go to IDLE.
  - In HOLD, go to IDLE next cycle.
  - done is not set in either case.
- start while busy: cur_idx restarts at 0 after the current ISSUE completes, or immediately from HOLD.
- DIRECT write while busy: data discarded, drop <= 1.
- Same-cycle W1C clear and hardware set: set wins.
- PATTERN writes mid-sequence take effect on the next read of that entry.
- PERIOD writes are applied at the next HOLD load.

Optional Feature:
- Macro: LEDSEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in ISSUE.
  - If m_response is not seen within TIMEOUT_CYCLES, m_write drops, err <= 1 and the FSM goes to IDLE (sequence aborted).
- Undefined: ISSUE waits indefinitely; err reads 0; no timeout logic is synthesized.

Decomposition:
- Shared package/header holds:
  - register offsets (CTRL, PERIOD, STATUS, DIRECT, PATTERN_BASE);
  - CTRL/STATUS bit positions;
  - FSM state encodings.
- One natural sub-module: led_sequencer_regs, the slave decode, register file, pattern table and W1C logic.
- The FSM and master port stay in the top level.

Test Plan:
- Direct write while idle:
  - Stimulus: write 0x0C=0xA5, with m_response tied to m_write.
  - Required: exactly one 1-cycle m_write with m_write_data=0x000000A5; busy returns to 0.
- One-shot run:
  - Setup: PATTERN[0..2]=0x01,0x02,0x04; PERIOD=4; CTRL: enable=1, last_idx=2, start=1.
  - Required: three writes spaced 4+1 cycles apart carrying 0x01,0x02,0x04, then done=1, busy=0.
- Loop run:
  - Stimulus: loop=1, same setup.
  - Required: data sequence 01,02,04,01,02,… continues.
  - Clearing enable during HOLD: IDLE within 1 cycle, done=0.
- Delayed response:
  - Stimulus: m_response delayed 3 cycles during ISSUE.
  - Required: m_write and m_write_data held 4 cycles.
  - Additionally: a DIRECT write during the run sets drop=1; writing 0x08 with bit9=1 clears it.
- Timeout (LEDSEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: m_response held 0.
  - Required: m_write deasserts after 16 cycles, err=1, busy=0.
  - Without the macro: m_write stays high.
- Reset mid-run:
  - Stimulus: assert reset during ISSUE.
  - Required: next cycle m_write=0, all registers read 0, and PERIOD=0 yields 1-cycle steps on the next run.
